cpu_clk_ctrl: RTL
=================

# cpu_clk_ctrl

Sequences the CPU clock derived from the 200 MHz board clock. It produces a glitch-free CPU clock at a fast or slow rate and switches between the two rates only at safe phase boundaries. It also supports halting the CPU clock and single-stepping it one period at a time from a push-button. It sits between the board clock buffer and the CPU/debug logic, and is the sole source of the CPU clock and its edge strobe.

## Interface
Parameters:
- FAST_LOG2, 2, log2 of fast half-period in clk200MHz cycles (default gives 25 MHz).
- SLOW_LOG2, 27, log2 of slow half-period.
- DEBOUNCE_CYCLES, 2000000, stable-cycles required on step_btn (debounce build only).

Ports:
- clk200MHz, in, 1, 200 MHz clock.
- rst, in, 1, reset; asynchronous, active-high.
- sw_slow, in, 1, async switch; 1 selects slow rate.
- halt_req, in, 1, async switch; 1 requests halt.
- step_btn, in, 1, async push-button; a press requests one CPU period while halted.
- clk_cpu, out, 1, registered CPU clock.
- cpu_rise, out, 1, one-cycle pulse in the cycle clk_cpu goes 0→1.
- halted, out, 1, high in HALTED state.
- mode_slow, out, 1, currently effective rate.
- edge_cnt, out, 32, count of clk_cpu rising edges; wraps at 2^32.

## Operation
- Synchronization: sw_slow, halt_req and step_btn each pass through a 2-flop synchronizer. Input-to-use latency is 2 cycles.
- Half-period counter half_cnt, SLOW_LOG2 bits wide:
  - Terminal value is 2^L−1, where L is FAST_LOG2 or SLOW_LOG2 according to mode_slow.
  - At terminal, clk_cpu toggles and half_cnt clears. Otherwise half_cnt increments.
- Rate switching: mode_slow is reloaded from the synchronized sw_slow only at a 1→0 toggle of clk_cpu, and on HALTED→RUN or HALTED→STEP exit.
  - A high phase is therefore never shortened or stretched mid-phase.
- States:
  - RUN: clk_cpu toggles continuously.
    - If halt_req is seen, the current period completes.
    - On the next 1→0 toggle (or immediately if clk_cpu=0 and half_cnt=0) → HALTED.
  - HALTED: clk_cpu=0 and half_cnt=0 are held.
    - halt_req low → RUN.
    - Step pulse → STEP (step has priority if both occur in the same cycle).
  - STEP: runs one full period (low half, then 0→1, then high half, then 1→0), then returns to HALTED.
    - If halt_req has dropped by then, goes to RUN instead.
- Step pulses arriving in RUN or STEP are discarded; they are not queued.
- cpu_rise is registered together with clk_cpu, and edge_cnt increments in the same cycle.
- Reset values: state RUN, clk_cpu=0, cpu_rise=0, halted=0, mode_slow=0, edge_cnt=0, half_cnt=0, synchronizers=0.

## Timing
- After rst release, clk_cpu first rises at the 2^FAST_LOG2-th clk200MHz edge.
  - With FAST_LOG2=2: high after the 4th edge, period 8 cycles, 50% duty.
- Halt response: clk_cpu stops low at most one CPU period + 2 cycles after halt_req.
- Step response: 2 sync cycles (+ debounce) + 2^L cycles low before the rise.
- rst asserted mid-period forces the reset values immediately, with no completion of the partial phase.

## Configuration
- CPU_CLK_CTRL_DEBOUNCE_EN defined:
  - The synchronized step_btn must hold a new level for DEBOUNCE_CYCLES consecutive cycles before it is accepted.
  - A step pulse is generated on the accepted 0→1 transition.
- Undefined:
  - The step pulse is the raw synchronized rising edge (1 cycle).
  - DEBOUNCE_CYCLES is ignored.

## Structure
- Package cpu_clk_pkg holds:
  - state enum typedef (RUN, HALTED, STEP);
  - synchronizer depth constant (2);
  - default FAST_LOG2 / SLOW_LOG2 / DEBOUNCE_CYCLES constants.
- Sub-module btn_debounce holds synchronizer + optional debounce + rise-pulse. It is instantiated once for step_btn.
- The sw_slow and halt_req synchronizers stay inline.

## Test plan
Simulation parameters: FAST_LOG2=2, SLOW_LOG2=4, DEBOUNCE_CYCLES=8.
- Reset release, all inputs 0 → clk_cpu period 8 cycles (4 high), cpu_rise once per period, edge_cnt=10 after 80 cycles.
- sw_slow raised mid-high-phase → current high phase stays 4 cycles, then 16-low/16-high periods; mode_slow changes exactly at the falling edge.
- halt_req raised → clk_cpu ends low within 8+2 cycles, halted=1, edge_cnt frozen.
- While halted, one step press (held 20 cycles) → exactly one cpu_rise, edge_cnt+1, back to HALTED; a second press during STEP is ignored.
- halt_req dropped during STEP → step period completes, then continuous RUN.
- rst pulsed while clk_cpu=1 → clk_cpu=0, edge_cnt=0, mode_slow=0 in the same cycle; normal restart follows.

Source files
------------

// File: rtl/cpu_clk_pkg.sv
// Shared types and defaults for the CPU clock sequencer.
// Optional step-button debounce is enabled by defining CPU_CLK_CTRL_DEBOUNCE_EN.
package cpu_clk_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALTED = 2'd1,
    STEP   = 2'd2
  } state_t;

  localparam int unsigned SYNC_STAGES = 2;

  localparam int unsigned DEF_FAST_LOG2       = 2;
  localparam int unsigned DEF_SLOW_LOG2       = 27;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 2000000;

endpackage

// File: rtl/btn_debounce.sv
// Push-button synchronizer with optional debounce (CPU_CLK_CTRL_DEBOUNCE_EN), producing a one-cycle press pulse.
// Latency: 2 sync cycles, plus DEBOUNCE_CYCLES and one register stage when debounce is enabled.
module btn_debounce
  import cpu_clk_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk200MHz,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   btn_s;

  assign btn_s = sync[SYNC_STAGES-1];

`ifdef CPU_CLK_CTRL_DEBOUNCE_EN
  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             level;
  logic [CNT_W-1:0] stable_cnt;

  // The accepted level only moves once the new level has held for the full window.
  always_ff @(posedge clk200MHz or posedge rst) begin
    if (rst) begin
      sync       <= '0;
      level      <= 1'b0;
      stable_cnt <= '0;
      pulse      <= 1'b0;
    end else begin
      sync  <= {sync[SYNC_STAGES-2:0], btn};
      pulse <= 1'b0;
      if (btn_s == level) begin
        stable_cnt <= '0;
      end else if (stable_cnt == CNT_LAST) begin
        level      <= btn_s;
        stable_cnt <= '0;
        pulse      <= btn_s;
      end else begin
        stable_cnt <= stable_cnt + 1'b1;
      end
    end
  end
`else
  logic btn_q;

  always_ff @(posedge clk200MHz or posedge rst) begin
    if (rst) begin
      sync  <= '0;
      btn_q <= 1'b0;
    end else begin
      sync  <= {sync[SYNC_STAGES-2:0], btn};
      btn_q <= btn_s;
    end
  end

  assign pulse = btn_s & ~btn_q;
`endif

  // A zero-length debounce window would make the accept logic meaningless.
  debounce_cfg_ok: assert property (@(posedge clk200MHz) disable iff (rst) DEBOUNCE_CYCLES != 0);

endmodule

// File: rtl/cpu_clk_ctrl.sv
// Glitch-free CPU clock sequencer: fast/slow rate, halt and single-step; rate changes land only on falling edges.
// Define CPU_CLK_CTRL_DEBOUNCE_EN to debounce step_btn over DEBOUNCE_CYCLES.
module cpu_clk_ctrl
  import cpu_clk_pkg::*;
#(
  parameter int unsigned FAST_LOG2       = DEF_FAST_LOG2,
  parameter int unsigned SLOW_LOG2       = DEF_SLOW_LOG2,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic        clk200MHz,
  input  logic        rst,
  input  logic        sw_slow,
  input  logic        halt_req,
  input  logic        step_btn,
  output logic        clk_cpu,
  output logic        cpu_rise,
  output logic        halted,
  output logic        mode_slow,
  output logic [31:0] edge_cnt
);

  localparam logic [SLOW_LOG2-1:0] FAST_TERM = SLOW_LOG2'((32'd1 << FAST_LOG2) - 32'd1);
  localparam logic [SLOW_LOG2-1:0] SLOW_TERM = '1;

  logic [SYNC_STAGES-1:0] slow_sync;
  logic [SYNC_STAGES-1:0] halt_sync;
  logic                   slow_s;
  logic                   halt_s;
  logic                   step_pulse;
  logic [SLOW_LOG2-1:0]   half_cnt;
  logic                   at_term;
  state_t                 state;

  always_ff @(posedge clk200MHz or posedge rst) begin
    if (rst) begin
      slow_sync <= '0;
      halt_sync <= '0;
    end else begin
      slow_sync <= {slow_sync[SYNC_STAGES-2:0], sw_slow};
      halt_sync <= {halt_sync[SYNC_STAGES-2:0], halt_req};
    end
  end

  assign slow_s = slow_sync[SYNC_STAGES-1];
  assign halt_s = halt_sync[SYNC_STAGES-1];

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_step_btn (
    .clk200MHz(clk200MHz),
    .rst      (rst),
    .btn      (step_btn),
    .pulse    (step_pulse)
  );

  assign at_term = (half_cnt == (mode_slow ? SLOW_TERM : FAST_TERM));

  // RUN and STEP share the phase counter; they differ only in when a halt is allowed to bite.
  always_ff @(posedge clk200MHz or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      clk_cpu   <= 1'b0;
      cpu_rise  <= 1'b0;
      halted    <= 1'b0;
      mode_slow <= 1'b0;
      edge_cnt  <= '0;
      half_cnt  <= '0;
    end else begin
      cpu_rise <= 1'b0;
      unique case (state)
        RUN, STEP: begin
          if (state == RUN && halt_s && !clk_cpu && half_cnt == '0) begin
            state  <= HALTED;
            halted <= 1'b1;
          end else if (at_term) begin
            half_cnt <= '0;
            clk_cpu  <= ~clk_cpu;
            if (!clk_cpu) begin
              cpu_rise <= 1'b1;
              edge_cnt <= edge_cnt + 32'd1;
            end else begin
              // Falling edge: the only point where the rate or the run state may change.
              mode_slow <= slow_s;
              state     <= halt_s ? HALTED : RUN;
              halted    <= halt_s;
            end
          end else begin
            half_cnt <= half_cnt + 1'b1;
          end
        end
        HALTED: begin
          if (step_pulse) begin
            state     <= STEP;
            halted    <= 1'b0;
            mode_slow <= slow_s;
          end else if (!halt_s) begin
            state     <= RUN;
            halted    <= 1'b0;
            mode_slow <= slow_s;
          end
        end
        default: begin
          state    <= RUN;
          halted   <= 1'b0;
          clk_cpu  <= 1'b0;
          half_cnt <= '0;
        end
      endcase
    end
  end

endmodule
